// File: rtl/load_ctrl.sv
// Block loader: fetches num_blocks 8-word AXI bursts into the load broadcaster,
// one outstanding burst at a time, handing each block to the consumer via blk_valid/blk_ready.
module load_ctrl #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_ID_VALUE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AXI_WIDTH_AD-1:0] base_addr,
  input  logic [15:0]             num_blocks,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [AXI_WIDTH_ID-1:0] m_axi_memory_bus_ARID,
  output logic [AXI_WIDTH_AD-1:0] m_axi_memory_bus_ARADDR,
  output logic [7:0]              m_axi_memory_bus_ARLEN,
  output logic [2:0]              m_axi_memory_bus_ARSIZE,
  output logic [1:0]              m_axi_memory_bus_ARBURST,
  output logic                    m_axi_memory_bus_ARVALID,
  input  logic                    m_axi_memory_bus_ARREADY,
  input  logic [1:0]              m_axi_memory_bus_RRESP,
  input  logic                    m_axi_memory_bus_RLAST,
  input  logic                    m_axi_memory_bus_RVALID,
  output logic                    m_axi_memory_bus_RREADY,
  output logic                    load_data_reg_wr_en,
  output logic [2:0]              sel_load_data,
  output logic                    blk_valid,
  input  logic                    blk_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // ADDR  | AR request for block blk_idx outstanding
  // DATA  | accepting the 8 beats of the current block
  // HOLD  | block complete in broadcaster, waiting for consumer
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [AXI_WIDTH_AD-1:0] base;
  logic [15:0]             nblk;
  logic [15:0]             blk_idx;
  logic [2:0]              beat_cnt;
  logic                    err_r;
  logic                    done_r;

  logic start_acc, ar_hs, beat_acc, beat_end, beat_bad, blk_hs, last_blk;
  logic arvalid_s, rready_s, blk_valid_s;

  assign start_acc = (state == IDLE) && start;
  assign ar_hs     = (state == ADDR) && m_axi_memory_bus_ARREADY;
  assign beat_acc  = (state == DATA) && m_axi_memory_bus_RVALID;
  assign beat_end  = beat_acc && ((beat_cnt == 3'd7) || m_axi_memory_bus_RLAST);
  // RLAST must coincide exactly with the eighth beat; either mismatch is a protocol error
  assign beat_bad  = beat_acc && ((m_axi_memory_bus_RRESP != 2'b00) ||
                                  ((beat_cnt == 3'd7) != m_axi_memory_bus_RLAST));
  assign blk_hs    = (state == HOLD) && blk_ready;
  assign last_blk  = (blk_idx == (nblk - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      nblk     <= '0;
      blk_idx  <= '0;
      beat_cnt <= '0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (start_acc && (num_blocks == 16'd0)) || (blk_hs && last_blk);
      if (start_acc) begin
        base    <= {base_addr[AXI_WIDTH_AD-1:5], 5'b0};
        nblk    <= num_blocks;
        blk_idx <= '0;
      end else if (blk_hs && !last_blk) begin
        blk_idx <= blk_idx + 16'd1;
      end
      if (ar_hs)
        beat_cnt <= '0;
      else if (beat_acc)
        beat_cnt <= beat_cnt + 3'd1;
      if (start_acc)
        err_r <= 1'b0;
      else if (beat_bad)
        err_r <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    arvalid_s   = 1'b0;
    rready_s    = 1'b0;
    blk_valid_s = 1'b0;
    case (state)
      IDLE: if (start && (num_blocks != 16'd0)) state_nxt = ADDR;
      ADDR: begin
        arvalid_s = 1'b1;
        if (m_axi_memory_bus_ARREADY) state_nxt = DATA;
      end
      DATA: begin
        rready_s = 1'b1;
        if (beat_end) state_nxt = HOLD;
      end
      HOLD: begin
        blk_valid_s = 1'b1;
        if (blk_ready) state_nxt = last_blk ? IDLE : ADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while rst is held so nothing leaks before the reset edge lands
  assign busy                     = (state != IDLE) && !rst;
  assign done                     = done_r && !rst;
  assign err                      = err_r && !rst;
  assign m_axi_memory_bus_ARVALID = arvalid_s && !rst;
  assign m_axi_memory_bus_RREADY  = rready_s && !rst;
  assign blk_valid                = blk_valid_s && !rst;
  assign load_data_reg_wr_en      = m_axi_memory_bus_RVALID && m_axi_memory_bus_RREADY;
  assign sel_load_data            = rst ? 3'd0 : beat_cnt;
  assign m_axi_memory_bus_ARADDR  = rst ? '0 : base + AXI_WIDTH_AD'({blk_idx, 5'b0});

  assign m_axi_memory_bus_ARID    = AXI_WIDTH_ID'(AXI_ID_VALUE);
  assign m_axi_memory_bus_ARLEN   = 8'd7;
  assign m_axi_memory_bus_ARSIZE  = 3'b010;
  assign m_axi_memory_bus_ARBURST = 2'b01;

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: job table, random jobs against a transaction-level
// reference model, and hand-written reset/abort sequences.
module tb_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_blocks;
  logic        busy, done, err;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        wr_en;
  logic [2:0]  sel;
  logic        blk_valid, blk_ready;

  int checks;
  int errors;
  bit exp_err;

  always #5 clk = ~clk;

  load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .busy(busy), .done(done), .err(err),
    .m_axi_memory_bus_ARID(ARID), .m_axi_memory_bus_ARADDR(ARADDR),
    .m_axi_memory_bus_ARLEN(ARLEN), .m_axi_memory_bus_ARSIZE(ARSIZE),
    .m_axi_memory_bus_ARBURST(ARBURST), .m_axi_memory_bus_ARVALID(ARVALID),
    .m_axi_memory_bus_ARREADY(ARREADY), .m_axi_memory_bus_RRESP(RRESP),
    .m_axi_memory_bus_RLAST(RLAST), .m_axi_memory_bus_RVALID(RVALID),
    .m_axi_memory_bus_RREADY(RREADY), .load_data_reg_wr_en(wr_en),
    .sel_load_data(sel), .blk_valid(blk_valid), .blk_ready(blk_ready)
  );

  typedef struct {
    logic [31:0] base;
    int          n, eb, lb, gaps, ard, ghost;
    int          x_ars, x_beats;
    logic [31:0] x_first, x_last;
    int          x_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_arvalid"}, 32'(ARVALID), 0);
    chk({tag, "_rready"}, 32'(RREADY), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_blk_valid"}, 32'(blk_valid), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_araddr"}, ARADDR, 0);
  endtask

  // Runs one job as AXI slave + consumer; the model tracks which phase of the job
  // we are in purely from observed handshakes and the rules for a job.
  task automatic run_job(input logic [31:0] b, input int n, input int err_beat, input int last_beat,
                         input int gaps, input int ar_delay, input int ghost,
                         output int ars, output int beats, output logic [31:0] first,
                         output logic [31:0] last, output logic err_end);
    logic [31:0] blk0;
    bit addr_ph, burst_open, hold, finished, busy_m, done_m;
    int beat, idx, ar_wait, hold_wait, rdy_delay, post, cyc, lb;
    blk0 = {b[31:5], 5'b0};
    ars = 0; beats = 0; first = 0; last = 0;
    addr_ph = 0; burst_open = 0; hold = 0; finished = 0; busy_m = 0; done_m = 0;
    beat = 0; idx = 0; ar_wait = 0; hold_wait = 0; post = -1; cyc = 0;
    rdy_delay = $urandom_range(0, 3);
    @(negedge clk);
    start = 1; base_addr = b; num_blocks = 16'(n);
    ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; blk_ready = 0;
    #1;
    chk("start_busy", 32'(busy), 0);
    chk("start_err_kept", 32'(err), 32'(exp_err));
    chk("start_arvalid", 32'(ARVALID), 0);
    exp_err = 0;
    if (n == 0) begin finished = 1; done_m = 1; post = 2; end
    else begin addr_ph = 1; busy_m = 1; end
    while (post != 0) begin
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL job_timeout: base %h blocks %0d busy=%0b expected job end", b, n, busy);
        break;
      end
      cyc++;
      @(negedge clk);
      start      = (ghost != 0) && (cyc == 3);
      base_addr  = 32'hDEAD_0000;
      num_blocks = 16'd9;
      lb         = (idx == 0) ? last_beat : 7;
      ARREADY    = ARVALID ? (ar_wait >= ar_delay) : 1'($urandom_range(0, 1));
      RVALID     = burst_open && ((gaps == 0) || ($urandom_range(0, 2) != 0));
      RLAST      = burst_open && (beat == lb);
      RRESP      = (burst_open && idx == 0 && beat == err_beat) ? 2'b10 : 2'b00;
      blk_ready  = blk_valid ? (hold_wait >= rdy_delay) : 1'($urandom_range(0, 1));
      #1;
      chk("busy", 32'(busy), 32'(busy_m));
      chk("done", 32'(done), 32'(done_m));
      chk("err", 32'(err), 32'(exp_err));
      chk("arvalid", 32'(ARVALID), 32'(addr_ph));
      chk("rready", 32'(RREADY), 32'(burst_open));
      chk("blk_valid", 32'(blk_valid), 32'(hold));
      chk("wr_en", 32'(wr_en), 32'(RVALID && burst_open));
      if (addr_ph) begin
        chk("araddr", ARADDR, blk0 + 32'(idx) * 32);
        chk("ar_fields", {16'(ARID), ARLEN, 3'(ARSIZE), 2'(ARBURST), 3'd0}, {16'd0, 8'd7, 3'b010, 2'b01, 3'd0});
      end
      if (burst_open && RVALID) chk("sel", 32'(sel), 32'(beat));
      done_m = 0;
      if (addr_ph) begin
        if (ARREADY) begin
          if (ars == 0) first = ARADDR;
          last = ARADDR; ars++;
          addr_ph = 0; burst_open = 1; beat = 0;
        end else ar_wait++;
      end else if (burst_open) begin
        if (RVALID) begin
          beats++;
          if (RRESP != 2'b00) exp_err = 1;
          if (beat == 7 || RLAST) begin
            if (!(beat == 7 && RLAST)) exp_err = 1;
            burst_open = 0; hold = 1; hold_wait = 0;
          end
          beat++;
        end
      end else if (hold) begin
        if (blk_ready) begin
          hold = 0; idx++;
          if (idx == n) begin busy_m = 0; done_m = 1; finished = 1; end
          else begin addr_ph = 1; ar_wait = 0; end
        end else hold_wait++;
      end
      if (finished && post < 0) post = 2;
      else if (post > 0) post--;
    end
    err_end = err;
  endtask

  task automatic job_and_compare(input string tag, input vec_t v);
    int ars, beats;
    logic [31:0] first, last;
    logic e;
    run_job(v.base, v.n, v.eb, v.lb, v.gaps, v.ard, v.ghost, ars, beats, first, last, e);
    chk({tag, "_ar_count"}, 32'(ars), 32'(v.x_ars));
    chk({tag, "_beats"}, 32'(beats), 32'(v.x_beats));
    if (v.x_ars > 0) begin
      chk({tag, "_first_addr"}, first, v.x_first);
      chk({tag, "_last_addr"}, last, v.x_last);
    end
    chk({tag, "_err_end"}, 32'(e), 32'(v.x_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    checks = 0; errors = 0; exp_err = 0;
    //           base           n eb lb gp ard gh  ars beats first          last          err
    vecs[0] = '{32'h0000_1000, 1, 8, 7, 0, 0, 0,   1,  8, 32'h0000_1000, 32'h0000_1000, 0};
    vecs[1] = '{32'h0000_101F, 3, 8, 7, 0, 0, 0,   3, 24, 32'h0000_1000, 32'h0000_1040, 0};
    vecs[2] = '{32'h0000_3000, 2, 8, 7, 1, 5, 1,   2, 16, 32'h0000_3000, 32'h0000_3020, 0};
    vecs[3] = '{32'h0000_2000, 1, 3, 7, 0, 0, 0,   1,  8, 32'h0000_2000, 32'h0000_2000, 1};
    vecs[4] = '{32'h0000_7000, 0, 8, 7, 0, 0, 0,   0,  0, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[5] = '{32'hFFFF_FFE7, 2, 8, 7, 0, 0, 0,   2, 16, 32'hFFFF_FFE0, 32'h0000_0000, 0};
    vecs[6] = '{32'h0000_4000, 2, 8, 4, 0, 0, 0,   2, 13, 32'h0000_4000, 32'h0000_4020, 1};

    rst = 1; start = 0; base_addr = 32'h1234_5678; num_blocks = 16'd3;
    ARREADY = 1; RVALID = 1; RLAST = 1; RRESP = 2'b11; blk_ready = 1;
    repeat (3) @(negedge clk);
    #1; check_all_zero("reset_hold");
    @(negedge clk);
    rst = 0; ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; blk_ready = 0;
    #1; check_all_zero("reset_idle");

    for (int i = 0; i < 7; i++) job_and_compare($sformatf("vec%0d", i), vecs[i]);

    // Abort mid-burst: reset while beat 4 is on the bus
    @(negedge clk);
    start = 1; base_addr = 32'h0000_5000; num_blocks = 16'd2;
    ARREADY = 1; RVALID = 0; RLAST = 0; RRESP = 0; blk_ready = 0;
    @(negedge clk);
    start = 0; #1;
    chk("mid_arvalid", 32'(ARVALID), 1);
    chk("mid_araddr", ARADDR, 32'h0000_5000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      RVALID = 1; #1;
      chk("mid_sel", 32'(sel), 32'(k));
      chk("mid_wr_en", 32'(wr_en), 1);
    end
    rst = 1; #1;
    check_all_zero("mid_in_reset");
    @(negedge clk);
    rst = 0; RVALID = 0; ARREADY = 0; #1;
    check_all_zero("mid_after_reset");
    exp_err = 0;
    job_and_compare("post_reset", '{32'h0000_6000, 1, 8, 7, 0, 0, 0, 1, 8, 32'h0000_6000, 32'h0000_6000, 0});

    for (int j = 0; j < 8; j++) begin
      rv.n     = $urandom_range(1, 4);
      rv.base  = $urandom;
      rv.eb    = $urandom_range(0, 15);
      rv.lb    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 7;
      rv.gaps  = 1;
      rv.ard   = $urandom_range(0, 6);
      rv.ghost = $urandom_range(0, 1);
      rv.x_ars   = rv.n;
      rv.x_beats = (rv.lb < 7) ? (rv.lb + 1) + (rv.n - 1) * 8 : rv.n * 8;
      rv.x_first = rv.base & 32'hFFFF_FFE0;
      rv.x_last  = rv.x_first + 32'(rv.n - 1) * 32;
      rv.x_err   = ((rv.eb <= rv.lb) || (rv.lb < 7)) ? 1 : 0;
      job_and_compare($sformatf("rand%0d", j), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_ctrl.md
LOAD_CTRL -- requirements
Module: load_ctrl

Interface
REQ-001 The block SHALL have parameter AXI_WIDTH_ID, default 4, meaning the AXI ID width in bits.
REQ-002 The block SHALL have parameter AXI_WIDTH_AD, default 32, meaning the AXI address width in bits.
REQ-003 The block SHALL have parameter AXI_ID_VALUE, default 0, meaning the constant ARID driven on every burst.
REQ-004 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, input, 1: the single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle job request.
- base_addr, input, AXI_WIDTH_AD: job start address.
- num_blocks, input, 16: number of 8-word blocks in the job.
- busy, output, 1: high while a job is active.
- done, output, 1: one-cycle job-complete pulse.
- err, output, 1: sticky response/protocol error flag.
- m_axi_memory_bus_ARID, output, AXI_WIDTH_ID: read address ID.
- m_axi_memory_bus_ARADDR, output, AXI_WIDTH_AD: read address.
- m_axi_memory_bus_ARLEN, output, 8: burst length.
- m_axi_memory_bus_ARSIZE, output, 3: beat size.
- m_axi_memory_bus_ARBURST, output, 2: burst type.
- m_axi_memory_bus_ARVALID, output, 1: read address valid.
- m_axi_memory_bus_ARREADY, input, 1: read address ready.
- m_axi_memory_bus_RRESP, input, 2: read response.
- m_axi_memory_bus_RLAST, input, 1: last beat of burst.
- m_axi_memory_bus_RVALID, input, 1: read data valid.
- m_axi_memory_bus_RREADY, output, 1: read data ready.
- load_data_reg_wr_en, output, 1: write enable to the load broadcaster register file.
- sel_load_data, output, 3: broadcaster word index (words 0-6 carry mantissas, word 7 carries the exponent).
- blk_valid, output, 1: a complete block is held in the broadcaster.
- blk_ready, input, 1: the consumer has taken the block.

Function
REQ-005 The block SHALL implement exactly four states, IDLE, ADDR, DATA and HOLD, plus a registered done pulse.
REQ-006 In IDLE, start=1 SHALL latch base_addr with bits [4:0] forced to 0, latch num_blocks, clear blk_idx, and assert busy from the next cycle.
REQ-007 If the latched num_blocks is 0, the block SHALL return to IDLE, pulse done one cycle after start, and issue no AXI traffic.
REQ-008 If num_blocks is not 0, the block SHALL enter ADDR.
REQ-009 start SHALL be ignored whenever busy=1.
REQ-010 In ADDR the block SHALL drive:
- ARVALID=1.
- ARADDR = base + blk_idx*32, modulo 2^AXI_WIDTH_AD.
- ARLEN=7, ARSIZE=3'b010, ARBURST=2'b01, ARID=AXI_ID_VALUE.
REQ-011 ARVALID and ARADDR SHALL remain stable until ARREADY=1; that handshake SHALL move the state to DATA and clear beat_cnt.
REQ-012 RREADY SHALL be 1 only in DATA.
REQ-013 load_data_reg_wr_en SHALL equal RVALID & RREADY combinationally, with zero latency, so each beat is captured by the broadcaster on the same edge.
REQ-014 sel_load_data SHALL equal beat_cnt (registered); beat_cnt SHALL increment on each accepted beat.
REQ-015 On the accepted beat with beat_cnt=7, the block SHALL enter HOLD; if RLAST=0 on that beat, err SHALL be set.
REQ-016 An accepted beat with RLAST=1 and beat_cnt<7 SHALL set err and enter HOLD; the remaining words keep their previous contents.
REQ-017 Any accepted beat with RRESP not equal to 2'b00 SHALL set err; data is still written and sequencing continues.
REQ-018 In HOLD, blk_valid SHALL be 1 and load_data_reg_wr_en SHALL be 0, so the broadcaster contents are frozen.
REQ-019 blk_valid SHALL stay high until blk_valid & blk_ready.
REQ-020 On the blk_valid & blk_ready handshake:
- If blk_idx = num_blocks-1, the state SHALL go to IDLE, busy SHALL drop, and done SHALL pulse in the next cycle.
- Otherwise blk_idx SHALL increment and the state SHALL go to ADDR.
REQ-021 The block SHALL allow at most one outstanding burst; a new AR is never issued before the previous block is consumed.
REQ-022 err SHALL clear only on rst or on an accepted start; it SHALL persist through done.
REQ-023 ADDR requires at least one cycle, so block-to-block latency is at least 1 AR cycle + 8 beats + 1 HOLD cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL force state IDLE and clear blk_idx, beat_cnt and err.
REQ-025 While in reset, all outputs SHALL be 0 (busy, done, err, ARVALID, RREADY, load_data_reg_wr_en, blk_valid, sel_load_data), and ARADDR SHALL be 0.
REQ-026 Reset mid-burst SHALL abandon the job immediately; the interconnect SHALL be reset in the same domain.

Verification
REQ-027 The bench SHALL cover: start, base 0x1000, 1 block, ARREADY and RVALID always 1 -> one AR with ARADDR 0x1000 and ARLEN 7; wr_en for 8 cycles with sel 0..7; blk_valid; blk_ready -> done pulse and busy=0.
REQ-028 The bench SHALL cover: 3 blocks, base 0x101F -> ARADDR 0x1000, 0x1020, 0x1040, each AR only after the prior blk_ready.
REQ-029 The bench SHALL cover: random RVALID gaps and ARREADY delayed 5 cycles -> ARADDR held stable, wr_en pulses only on valid beats, sel strictly 0..7.
REQ-030 The bench SHALL cover: RRESP=2'b10 on beat 3 -> err=1 after that edge, all 8 beats written, done still pulses, err held until next start.
REQ-031 The bench SHALL cover: num_blocks 0 -> done one cycle after start, ARVALID never asserted; start while busy -> ignored.
REQ-032 The bench SHALL cover: rst during beat 4 -> next cycle all outputs 0 and state IDLE; a fresh start then runs normally from sel 0.
